// File: rtl/int_ctrl_pkg.sv
// Shared types and defaults for the Gumnut interrupt controller.
package int_ctrl_pkg;

  localparam int PC_W = 12;

  localparam int              DEF_NUM_IRQ    = 4;
  localparam logic [PC_W-1:0] DEF_VEC_BASE   = 12'h001;
  localparam int              DEF_VEC_STRIDE = 2;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    ISR,
    RESTORE
  } state_e;

  // A single source still needs a 1-bit id so the port never collapses to zero width.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins. Purely combinational.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int N    = DEF_NUM_IRQ,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req_i,
  output logic [ID_W-1:0] id_o,
  output logic            vld_o
);

  // Scan downward so the last hit, i.e. the lowest index, is the one kept.
  always_comb begin
    id_o  = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o  = ID_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched requests, masked fixed-priority arbitration,
// and a SAVE/ISR/RESTORE entry-return sequence without nesting.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int              NUM_IRQ    = DEF_NUM_IRQ,
  parameter logic [PC_W-1:0] VEC_BASE   = DEF_VEC_BASE,
  parameter int              VEC_STRIDE = DEF_VEC_STRIDE,
  localparam int             ID_W       = id_width(NUM_IRQ)
) (
  input  logic               gClk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               mask_we_i,
  input  logic [NUM_IRQ-1:0] mask_i,
  input  logic               enai_i,
  input  logic               disi_i,
  input  logic               boundary_i,
  input  logic               reti_i,
  output logic               save_we_o,
  output logic               restore_o,
  output logic               pc_load_o,
  output logic [PC_W-1:0]    vector_pc_o,
  output logic [NUM_IRQ-1:0] ack_o,
  output logic [ID_W-1:0]    active_id_o,
  output logic               ie_o,
  output logic               busy_o,
  output logic [NUM_IRQ-1:0] pending_o
);

  state_e               state_q, state_d;
  logic [NUM_IRQ-1:0]   irq_prev_q, irq_prev_d;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   mask_q, mask_d;
  logic                 ie_q, ie_d;
  logic [ID_W-1:0]      active_id_q, active_id_d;
  logic [PC_W-1:0]      vector_q, vector_d;

  logic [NUM_IRQ-1:0]   edge_w;
  logic [NUM_IRQ-1:0]   eligible_w;
  logic [NUM_IRQ-1:0]   ack_w;
  logic [ID_W-1:0]      win_id_w;
  logic                 win_vld_w;
  logic [PC_W-1:0]      vec_calc_w;

  assign edge_w     = irq_i & ~irq_prev_q;
  assign eligible_w = pending_q & ~mask_q;
  assign vec_calc_w = VEC_BASE + PC_W'(win_id_w) * PC_W'(VEC_STRIDE);

  int_prio_enc #(
    .N    (NUM_IRQ),
    .ID_W (ID_W)
  ) u_prio (
    .req_i (eligible_w),
    .id_o  (win_id_w),
    .vld_o (win_vld_w)
  );

  always_comb begin
    ack_w = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_w[i] = (state_q == SAVE) && (active_id_q == ID_W'(i));
    end
  end

  always_ff @(posedge gClk) begin
    if (rst) begin
      state_q     <= IDLE;
      irq_prev_q  <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      ie_q        <= 1'b0;
      active_id_q <= '0;
      vector_q    <= VEC_BASE;
    end else begin
      state_q     <= state_d;
      irq_prev_q  <= irq_prev_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      ie_q        <= ie_d;
      active_id_q <= active_id_d;
      vector_q    <= vector_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    irq_prev_d  = irq_i;
    // A fresh edge on the line being acknowledged must not be lost.
    pending_d   = (pending_q & ~ack_w) | edge_w;
    mask_d      = mask_we_i ? mask_i : mask_q;
    ie_d        = ie_q;
    active_id_d = active_id_q;
    vector_d    = vector_q;

    case (state_q)
      IDLE: begin
        if (disi_i) begin
          ie_d = 1'b0;
        end else if (enai_i) begin
          ie_d = 1'b1;
        end
        if (ie_q && boundary_i && win_vld_w) begin
          state_d     = SAVE;
          active_id_d = win_id_w;
          vector_d    = vec_calc_w;
        end
      end
      SAVE: begin
        ie_d    = 1'b0;
        state_d = ISR;
      end
      ISR: begin
        if (reti_i) begin
          state_d = RESTORE;
        end
      end
      RESTORE: begin
        ie_d    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign save_we_o   = (state_q == SAVE);
  assign pc_load_o   = (state_q == SAVE);
  assign restore_o   = (state_q == RESTORE);
  assign ack_o       = ack_w;
  assign busy_o      = (state_q != IDLE);
  assign ie_o        = ie_q;
  assign active_id_o = active_id_q;
  assign vector_pc_o = vector_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed sequences plus a scoreboard of expected SAVE events.
module tb_int_ctrl;

  logic        gClk = 1'b0;
  logic        rst;
  logic [3:0]  irq_i;
  logic        mask_we_i;
  logic [3:0]  mask_i;
  logic        enai_i;
  logic        disi_i;
  logic        boundary_i;
  logic        reti_i;
  logic        save_we_o;
  logic        restore_o;
  logic        pc_load_o;
  logic [11:0] vector_pc_o;
  logic [3:0]  ack_o;
  logic [1:0]  active_id_o;
  logic        ie_o;
  logic        busy_o;
  logic [3:0]  pending_o;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  ack;
    logic [11:0] vec;
    logic [1:0]  id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int_ctrl dut (
    .gClk        (gClk),
    .rst         (rst),
    .irq_i       (irq_i),
    .mask_we_i   (mask_we_i),
    .mask_i      (mask_i),
    .enai_i      (enai_i),
    .disi_i      (disi_i),
    .boundary_i  (boundary_i),
    .reti_i      (reti_i),
    .save_we_o   (save_we_o),
    .restore_o   (restore_o),
    .pc_load_o   (pc_load_o),
    .vector_pc_o (vector_pc_o),
    .ack_o       (ack_o),
    .active_id_o (active_id_o),
    .ie_o        (ie_o),
    .busy_o      (busy_o),
    .pending_o   (pending_o)
  );

  always #5 gClk = ~gClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Vector model: base 1, stride 2 instruction words.
  function automatic void push_exp(input int id);
    exp_t e;
    e.ack = 4'b0001 << id;
    e.vec = 12'(1 + 2 * id);
    e.id  = 2'(id);
    sb.push_back(e);
  endfunction

  always @(negedge gClk) begin
    if (save_we_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_save", 32'(save_we_o), 0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_ack",        32'(ack_o),       32'(mon_e.ack));
        check("sb_vector",     32'(vector_pc_o), 32'(mon_e.vec));
        check("sb_active_id",  32'(active_id_o), 32'(mon_e.id));
        check("sb_pc_load",    32'(pc_load_o),   1);
        check("sb_no_restore", 32'(restore_o),   0);
      end
    end
  end

  task automatic step();
    @(posedge gClk);
    #1;
  endtask

  task automatic wait_save();
    int n = 0;
    while (save_we_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("save_seen", 32'(save_we_o), 1);
  endtask

  // Entered in the first ISR cycle; leaves the controller back in IDLE.
  task automatic finish_isr();
    check("isr_ie",   32'(ie_o),   0);
    check("isr_busy", 32'(busy_o), 1);
    step();
    step();
    check("isr_no_nest", 32'(save_we_o), 0);
    reti_i = 1'b1;
    step();
    reti_i = 1'b0;
    check("restore_pulse", 32'(restore_o), 1);
    check("restore_ie",    32'(ie_o),      0);
    step();
    check("restore_end", 32'(restore_o), 0);
    check("return_ie",   32'(ie_o),      1);
    check("return_idle", 32'(busy_o),    0);
  endtask

  task automatic serve();
    wait_save();
    step();
    finish_isr();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; irq_i = 4'b1111; mask_we_i = 1'b0; mask_i = '0;
    enai_i = 1'b0; disi_i = 1'b0; boundary_i = 1'b1; reti_i = 1'b0;

    // Reset hold with all lines high.
    step(); step(); step();
    check("rst_pending", 32'(pending_o),   0);
    check("rst_ie",      32'(ie_o),        0);
    check("rst_busy",    32'(busy_o),      0);
    check("rst_vector",  32'(vector_pc_o), 'h001);
    check("rst_id",      32'(active_id_o), 0);
    check("rst_ack",     32'(ack_o),       0);
    check("rst_save",    32'(save_we_o),   0);
    check("rst_restore", 32'(restore_o),   0);
    check("rst_pc_load", 32'(pc_load_o),   0);
    rst = 1'b0;
    step();
    check("post_rst_pending", 32'(pending_o), 'b1111);
    step(); step();
    check("post_rst_no_save", 32'(busy_o), 0);
    check("post_rst_ie",      32'(ie_o),   0);

    // Enable and drain all four in priority order.
    for (int i = 0; i < 4; i++) push_exp(i);
    enai_i = 1'b1;
    step();
    enai_i = 1'b0;
    check("enai_ie", 32'(ie_o), 1);
    serve();
    for (int i = 1; i < 4; i++) begin
      step();
      check("reentry_r3", 32'(save_we_o), 1);
      serve();
    end
    irq_i = 4'b0000;
    step();
    check("drained", 32'(pending_o), 0);

    // Single request, then a new edge on the same line during SAVE.
    irq_i = 4'b0100;
    push_exp(2);
    step();
    check("single_pending_t1", 32'(pending_o), 'b0100);
    check("single_no_save_t1", 32'(save_we_o), 0);
    irq_i = 4'b0000;
    step();
    check("single_save_t2", 32'(save_we_o), 1);
    irq_i = 4'b0100;
    step();
    check("set_wins", 32'(pending_o), 'b0100);
    push_exp(2);
    finish_isr();
    step();
    check("reentry_same", 32'(save_we_o), 1);
    serve();
    irq_i = 4'b0000;

    // Simultaneous requests: lower index first.
    irq_i = 4'b1010;
    push_exp(1);
    push_exp(3);
    serve();
    step();
    check("prio_reentry", 32'(save_we_o), 1);
    serve();
    irq_i = 4'b0000;

    // Masked source stays pending until unmasked.
    mask_we_i = 1'b1; mask_i = 4'b0010;
    step();
    mask_we_i = 1'b0;
    irq_i = 4'b0010;
    step();
    check("mask_pending", 32'(pending_o), 'b0010);
    step(); step(); step();
    check("mask_no_save", 32'(busy_o), 0);
    push_exp(1);
    mask_we_i = 1'b1; mask_i = 4'b0000;
    step();
    mask_we_i = 1'b0;
    serve();
    irq_i = 4'b0000;

    // reti outside ISR is ignored.
    reti_i = 1'b1;
    step();
    reti_i = 1'b0;
    step();
    check("reti_idle_busy",    32'(busy_o),    0);
    check("reti_idle_restore", 32'(restore_o), 0);
    check("reti_idle_ie",      32'(ie_o),      1);

    // disi beats enai.
    enai_i = 1'b1; disi_i = 1'b1;
    step();
    enai_i = 1'b0; disi_i = 1'b0;
    check("enai_disi_ie", 32'(ie_o), 0);
    enai_i = 1'b1;
    step();
    enai_i = 1'b0;
    check("enai_again_ie", 32'(ie_o), 1);

    // Reset while in ISR.
    irq_i = 4'b0001;
    push_exp(0);
    wait_save();
    step();
    check("pre_rst_busy", 32'(busy_o), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("isr_rst_busy",    32'(busy_o),      0);
    check("isr_rst_ie",      32'(ie_o),        0);
    check("isr_rst_restore", 32'(restore_o),   0);
    check("isr_rst_pending", 32'(pending_o),   0);
    check("isr_rst_vector",  32'(vector_pc_o), 'h001);
    step();
    check("isr_rst_repend",   32'(pending_o), 'b0001);
    check("isr_rst_restore2", 32'(restore_o), 0);
    check("isr_rst_idle",     32'(busy_o),    0);
    irq_i = 4'b0000;
    step(); step();

    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
